// File: rtl/adc_lane_aligner.sv
// Multi-lane ADC sample aligner: per-lane FIFOs realigned on the sync-tagged sample.
// Optional sync-word statistics counter enabled by ADC_LANE_ALIGNER_SYNC_STATS_EN.
module adc_lane_aligner #(
  parameter int NUM_CH        = 4,
  parameter int DATA_W        = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int ALIGN_TIMEOUT = 64
) (
  input  logic                     user_clk,
  input  logic                     reset_n,
  input  logic                     arm,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  input  logic [NUM_CH-1:0]        adc_valid,
  input  logic [NUM_CH-1:0]        adc_sync,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic                     valid,
  output logic                     sync,
  output logic                     locked,
  output logic                     error,
  output logic                     overflow,
  output logic [1:0]               state,
  output logic [15:0]              sync_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ALIGN_TIMEOUT + 1);
  localparam int EW = DATA_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [NUM_CH-1:0]          captured_q, captured_d;
  logic [NUM_CH-1:0]          capture_now, push_req, push, ovf_lane;
  logic [NUM_CH-1:0]          full, empty, head_sync;
  logic [NUM_CH*DATA_W-1:0]   head_data;
  logic [TW-1:0]              timer_q, timer_d;
  logic                       error_q, error_d, overflow_q, overflow_d;
  logic                       pop, misalign;
  logic [NUM_CH*DATA_W-1:0]   data_out_q;
  logic                       valid_q, sync_q;

  // A pop only happens when every lane has a word, so lanes advance in lockstep.
  assign pop      = !arm && (state_q == ST_LOCKED) && (empty == '0);
  assign misalign = (head_sync != '0) && (head_sync != '1);

  always_comb begin
    capture_now = '0;
    push_req    = '0;
    ovf_lane    = '0;
    push        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      capture_now[i] = (state_q == ST_SEARCH) && adc_valid[i] && adc_sync[i] && !captured_q[i];
      push_req[i]    = !arm && adc_valid[i] &&
                       (((state_q == ST_SEARCH) && (captured_q[i] || adc_sync[i])) ||
                        (state_q == ST_LOCKED));
      ovf_lane[i]    = push_req[i] && full[i] && !pop;
      push[i]        = push_req[i] && !ovf_lane[i];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    assign full[i]                         = (count_q == CW'(FIFO_DEPTH));
    assign empty[i]                        = (count_q == '0);
    assign head_data[i*DATA_W +: DATA_W]   = mem_q[rd_ptr_q][DATA_W-1:0];
    assign head_sync[i]                    = mem_q[rd_ptr_q][DATA_W];

    always_ff @(posedge user_clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else if (arm) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push[i]) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + CW'(push[i]) - CW'(pop);
      end
    end

    always_ff @(posedge user_clk) begin
      if (push[i]) mem_q[wr_ptr_q] <= {adc_sync[i], adc_data[i*DATA_W +: DATA_W]};
    end
  end

  always_comb begin
    state_d    = state_q;
    captured_d = captured_q;
    timer_d    = timer_q;
    error_d    = error_q;
    overflow_d = overflow_q;
    if (arm) begin
      state_d    = ST_SEARCH;
      captured_d = '0;
      timer_d    = '0;
      error_d    = 1'b0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          captured_d = captured_q | capture_now;
          if (captured_d != '0) timer_d = timer_q + TW'(1);
          // Completing capture wins over a timeout landing on the same cycle.
          if (ovf_lane != '0) begin
            state_d    = ST_ERROR;
            error_d    = 1'b1;
            overflow_d = 1'b1;
          end else if (captured_d == '1) begin
            state_d = ST_LOCKED;
          end else if ((captured_d != '0) && (timer_d == TW'(ALIGN_TIMEOUT))) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (ovf_lane != '0) begin
            state_d    = ST_ERROR;
            error_d    = 1'b1;
            overflow_d = 1'b1;
          end
          if (pop && misalign) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      captured_q <= '0;
      timer_q    <= '0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      captured_q <= captured_d;
      timer_q    <= timer_d;
      error_q    <= error_d;
      overflow_q <= overflow_d;
      valid_q    <= pop;
      sync_q     <= pop && (head_sync == '1);
      if (pop) data_out_q <= head_data;
    end
  end

`ifdef ADC_LANE_ALIGNER_SYNC_STATS_EN
  logic [15:0] sync_count_q;

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_count_q <= '0;
    end else if (arm) begin
      sync_count_q <= '0;
    end else if (valid_q && sync_q && (sync_count_q != 16'hFFFF)) begin
      sync_count_q <= sync_count_q + 16'd1;
    end
  end

  assign sync_count = sync_count_q;
`else
  assign sync_count = '0;
`endif

  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign sync     = sync_q;
  assign locked   = (state_q == ST_LOCKED);
  assign error    = error_q;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule

// File: tb/tb_adc_lane_aligner.sv
// Self-checking bench for adc_lane_aligner: vector table, directed corner cases and
// randomized skewed streams checked against a queue-based reference model.
module tb_adc_lane_aligner;

  localparam int NUM_CH        = 4;
  localparam int DATA_W        = 8;
  localparam int FIFO_DEPTH    = 8;
  localparam int ALIGN_TIMEOUT = 64;
  localparam int W             = NUM_CH * DATA_W;
`ifdef ADC_LANE_ALIGNER_SYNC_STATS_EN
  localparam int STATS_EXP = 3;
`else
  localparam int STATS_EXP = 0;
`endif

  logic              user_clk = 1'b0;
  logic              reset_n;
  logic              arm;
  logic [W-1:0]      adc_data;
  logic [NUM_CH-1:0] adc_valid;
  logic [NUM_CH-1:0] adc_sync;
  logic [W-1:0]      data_out;
  logic              valid, sync, locked, error, overflow;
  logic [1:0]        state;
  logic [15:0]       sync_count;

  int checks   = 0;
  int failures = 0;

  adc_lane_aligner #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ALIGN_TIMEOUT(ALIGN_TIMEOUT)
  ) dut (
    .user_clk(user_clk), .reset_n(reset_n), .arm(arm), .adc_data(adc_data),
    .adc_valid(adc_valid), .adc_sync(adc_sync), .data_out(data_out), .valid(valid),
    .sync(sync), .locked(locked), .error(error), .overflow(overflow), .state(state),
    .sync_count(sync_count)
  );

  always #5 user_clk = ~user_clk;

  // Reference model: lane FIFOs as queues, state as the numeric codes 0..3.
  logic [DATA_W:0] mQ [NUM_CH][$];
  int              mState, mTimer, mCount;
  bit              mCap [NUM_CH];
  bit              mValid, mSync, mError, mOvf;
  logic [W-1:0]    mData;

  task automatic modelReset();
    for (int i = 0; i < NUM_CH; i++) begin
      mQ[i].delete();
      mCap[i] = 1'b0;
    end
    mState = 0; mTimer = 0; mCount = 0;
    mValid = 0; mSync = 0; mError = 0; mOvf = 0; mData = '0;
  endtask

  task automatic modelStep(input bit a, input logic [W-1:0] d,
                           input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] s);
    bit popOk, ovfHit, anyCap, allCap, syncAnd, syncOr;
    logic [DATA_W:0] e;
    if (a) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mQ[i].delete();
        mCap[i] = 1'b0;
      end
      mTimer = 0; mError = 0; mOvf = 0; mState = 1; mValid = 0; mSync = 0; mCount = 0;
      return;
    end
`ifdef ADC_LANE_ALIGNER_SYNC_STATS_EN
    if (mValid && mSync && mCount < 65535) mCount++;
`endif
    popOk = (mState == 2);
    for (int i = 0; i < NUM_CH; i++) if (mQ[i].size() == 0) popOk = 0;
    syncAnd = 1; syncOr = 0;
    if (popOk) begin
      for (int i = 0; i < NUM_CH; i++) begin
        e = mQ[i].pop_front();
        mData[i*DATA_W +: DATA_W] = e[DATA_W-1:0];
        syncAnd &= e[DATA_W];
        syncOr  |= e[DATA_W];
      end
    end
    mValid = popOk;
    mSync  = popOk && syncAnd;
    ovfHit = 0;
    if (mState == 1 || mState == 2) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (v[i] && (mState == 2 || mCap[i] || s[i])) begin
          mCap[i] = 1'b1;
          if (mQ[i].size() >= FIFO_DEPTH) ovfHit = 1;
          else mQ[i].push_back({s[i], d[i*DATA_W +: DATA_W]});
        end
      end
    end
    if (mState == 1) begin
      anyCap = 0; allCap = 1;
      for (int i = 0; i < NUM_CH; i++) begin
        anyCap |= mCap[i];
        allCap &= mCap[i];
      end
      if (anyCap) mTimer++;
      if (ovfHit) begin
        mState = 3; mError = 1; mOvf = 1;
      end else if (allCap) begin
        mState = 2;
      end else if (anyCap && mTimer >= ALIGN_TIMEOUT) begin
        mState = 3; mError = 1;
      end
    end else if (mState == 2) begin
      if (ovfHit) begin
        mState = 3; mError = 1; mOvf = 1;
      end
      if (popOk && syncOr && !syncAnd) begin
        mState = 3; mError = 1;
      end
    end
  endtask

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    logic [W+22:0] act, exp;
    act = {state, locked, error, overflow, valid, sync, data_out, sync_count};
    exp = {2'(mState), mState == 2, mError, mOvf, mValid, mSync, mData, 16'(mCount)};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit a, input logic [W-1:0] d,
                               input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] s,
                               input string name);
    arm = a; adc_data = d; adc_valid = v; adc_sync = s;
    @(posedge user_clk);
    #1;
    modelStep(a, d, v, s);
    checkOutput(name);
  endtask

  function automatic logic [W-1:0] rep(input logic [DATA_W-1:0] b);
    return {NUM_CH{b}};
  endfunction

  typedef struct {
    bit               a;
    logic [7:0]       b;
    logic [3:0]       v;
    logic [3:0]       s;
    logic [1:0]       st;
    bit               val;
    bit               syn;
    logic [31:0]      dat;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0]      d;
    logic [NUM_CH-1:0] v, s;
    logic [7:0]        seqData [NUM_CH][64];
    int                sk [NUM_CH];
    int                n, mode;
    bit                found;

    tbl[0]  = '{1'b1, 8'h00, 4'h0, 4'h0, 2'd1, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 8'h0C, 4'hF, 4'h0, 2'd1, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 8'h0D, 4'hF, 4'h0, 2'd1, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 8'h0E, 4'hF, 4'h0, 2'd1, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 8'h0F, 4'hF, 4'h0, 2'd1, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 8'h10, 4'hF, 4'hF, 2'd2, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 8'h11, 4'hF, 4'h0, 2'd2, 1'b1, 1'b1, 32'h10101010};
    tbl[7]  = '{1'b0, 8'h12, 4'hF, 4'h0, 2'd2, 1'b1, 1'b0, 32'h11111111};
    tbl[8]  = '{1'b0, 8'h13, 4'hF, 4'h0, 2'd2, 1'b1, 1'b0, 32'h12121212};
    tbl[9]  = '{1'b0, 8'h00, 4'h0, 4'h0, 2'd2, 1'b1, 1'b0, 32'h13131313};
    tbl[10] = '{1'b0, 8'h00, 4'h0, 4'h0, 2'd2, 1'b0, 1'b0, 32'h13131313};

    reset_n = 1'b0; arm = 1'b0; adc_data = '0; adc_valid = '0; adc_sync = '0;
    modelReset();
    #22;
    checkVal("reset_outputs", {state, locked, error, overflow, valid, sync, data_out, sync_count}, '0);
    @(posedge user_clk);
    #1;
    reset_n = 1'b1;
    checkOutput("reset_model");

    applyStimulus(0, rep(8'hAA), '1, '1, "idle_ignores");

    // Zero skew: every lane syncs on the same sample.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].a, rep(tbl[i].b), tbl[i].v, tbl[i].s, "zero_skew");
      checkVal("zs_state", state, tbl[i].st);
      checkVal("zs_valid_sync", {valid, sync}, {tbl[i].val, tbl[i].syn});
      checkVal("zs_data", data_out, tbl[i].dat);
    end

    // Lane 2 runs three cycles late; the tagged word must still come out together.
    applyStimulus(1, '0, '0, '0, "skew_arm");
    found = 0;
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        n = c - ((i == 2) ? 3 : 0);
        v[i] = (n >= 0);
        s[i] = (n == 2);
        d[i*DATA_W +: DATA_W] = {4'(i), 4'(n)};
      end
      applyStimulus(0, d, v, s, "skew");
      if (valid && sync && !found) begin
        found = 1;
        checkVal("skew_word", data_out, 32'h32221202);
      end
    end
    checkVal("skew_found", found, 1);
    checkVal("skew_no_error", {state, error}, {2'd2, 1'b0});

    // Lane 3 never syncs: ERROR lands exactly ALIGN_TIMEOUT cycles after the first sync.
    applyStimulus(1, '0, '0, '0, "tmo_arm");
    for (int k = 0; k < ALIGN_TIMEOUT; k++) begin
      if (k == 0) applyStimulus(0, rep(8'h55), 4'b0111, 4'b0111, "tmo");
      else        applyStimulus(0, rep(8'h00), 4'b0000, 4'b0000, "tmo");
      if (k == ALIGN_TIMEOUT - 2) checkVal("tmo_before", {state, error}, {2'd1, 1'b0});
      if (k == ALIGN_TIMEOUT - 1) checkVal("tmo_state", {state, error, valid}, {2'd3, 1'b1, 1'b0});
    end

    // Lane 1 stalls while the others fill their FIFOs.
    applyStimulus(1, '0, '0, '0, "ovf_arm");
    applyStimulus(0, rep(8'h20), 4'hF, 4'hF, "ovf_lock");
    for (int k = 1; k <= FIFO_DEPTH + 1; k++) begin
      applyStimulus(0, rep(8'(8'h20 + k)), 4'b1101, 4'b0000, "ovf_fill");
      if (k == FIFO_DEPTH)     checkVal("ovf_before", {state, overflow}, {2'd2, 1'b0});
      if (k == FIFO_DEPTH + 1) checkVal("ovf_hit", {state, overflow}, {2'd3, 1'b1});
    end
    applyStimulus(1, '0, '0, '0, "ovf_rearm");
    checkVal("ovf_cleared", {state, overflow, error}, {2'd1, 1'b0, 1'b0});

    // A sync tag on lane 0 alone breaks alignment.
    applyStimulus(0, rep(8'h40), 4'hF, 4'hF, "mis_lock");
    applyStimulus(0, rep(8'h41), 4'hF, 4'h0, "mis_stream");
    applyStimulus(0, rep(8'h42), 4'hF, 4'h1, "mis_inject");
    applyStimulus(0, rep(8'h43), 4'hF, 4'h0, "mis_pop");
    checkVal("mis_word", {valid, sync, state, error, data_out}, {1'b1, 1'b0, 2'd3, 1'b1, 32'h42424242});
    applyStimulus(0, rep(8'h44), 4'hF, 4'h0, "mis_after");
    checkVal("mis_valid_low", valid, 0);

    // Re-arm mid-LOCKED, then count aligned sync words.
    applyStimulus(1, '0, '0, '0, "stats_arm0");
    applyStimulus(0, rep(8'h60), 4'hF, 4'hF, "stats_lock0");
    applyStimulus(0, rep(8'h61), 4'hF, 4'hF, "stats_run0");
    applyStimulus(0, rep(8'h62), 4'hF, 4'h0, "stats_run0");
    applyStimulus(1, rep(8'h63), 4'hF, 4'hF, "stats_rearm");
    checkVal("rearm_state", {state, valid, sync_count}, {2'd1, 1'b0, 16'd0});
    applyStimulus(0, rep(8'h70), 4'hF, 4'hF, "stats_sync1");
    applyStimulus(0, rep(8'h71), 4'hF, 4'hF, "stats_sync2");
    checkVal("rearm_fresh_word", data_out, 32'h70707070);
    applyStimulus(0, rep(8'h72), 4'hF, 4'hF, "stats_sync3");
    for (int k = 0; k < 4; k++) applyStimulus(0, rep(8'(8'h73 + k)), 4'hF, 4'h0, "stats_tail");
    checkVal("sync_count", sync_count, 16'(STATS_EXP));

    // Randomized skewed streams: clean, with dropouts, and fully random.
    for (int ep = 0; ep < 12; ep++) begin
      mode = ep % 3;
      for (int i = 0; i < NUM_CH; i++) begin
        sk[i] = $urandom_range(0, 5);
        for (int j = 0; j < 64; j++) seqData[i][j] = 8'($urandom);
      end
      applyStimulus(1, '0, '0, '0, "rand_arm");
      for (int c = 0; c < 40; c++) begin
        for (int i = 0; i < NUM_CH; i++) begin
          n = c - sk[i];
          if (mode == 2) begin
            v[i] = ($urandom_range(0, 3) != 0);
            s[i] = ($urandom_range(0, 9) == 0);
            d[i*DATA_W +: DATA_W] = 8'($urandom);
          end else begin
            v[i] = (n >= 0) && (mode == 0 || $urandom_range(0, 19) != 0);
            s[i] = (n >= 0) && (n % 8 == 3);
            d[i*DATA_W +: DATA_W] = (n >= 0) ? seqData[i][n] : 8'h00;
          end
        end
        applyStimulus($urandom_range(0, 59) == 0, d, v, s, "random");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
